// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: 2-flop synchroniser, per-channel stability counter, press/release pulses.
// Optional long-press detection is compiled in with macro DEBOUNCE_LONGPRESS_EN (adds parameter LONG_CYCLES).
module debounce_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 20,
  parameter int DB_CYCLES   = 500000,
  parameter int ACTIVE_LOW  = 0
`ifdef DEBOUNCE_LONGPRESS_EN
  ,
  parameter int LONG_CYCLES = 1500000
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_CH-1:0] w_in;
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  assign w_in = (ACTIVE_LOW != 0) ? ~button_in : button_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_press;
    logic             r_rel;
    logic             w_diff;
    logic             w_accept;

    assign w_diff   = r_sync2[g] ^ r_db;
    assign w_accept = w_diff && (r_cnt == DB_LAST);

    // Acceptance clears the counter on the same edge, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_db    <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_press <= w_accept && r_sync2[g];
        r_rel   <= w_accept && !r_sync2[g];
        if (!w_diff || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_accept) begin
          r_db <= r_sync2[g];
        end
      end
    end

    assign db_out[g]        = r_db;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_rel;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int              LONG_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] r_lcnt;
    logic              r_long;

    // High-time counter parks at LONG_CYCLES, giving one pulse per press.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_lcnt <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= 1'b0;
        if (!r_db) begin
          r_lcnt <= '0;
        end else if (r_lcnt != LONG_MAX) begin
          r_lcnt <= r_lcnt + LONG_W'(1);
          r_long <= (r_lcnt == LONG_LAST);
        end
      end
    end

    assign long_pulse[g] = r_long;
`else
    assign long_pulse[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised and directed bench for debounce_multi with a window-based reference model and pulse scoreboard.
module tb_debounce_multi;

  localparam int DB   = 16;
  localparam int LONG = 64;
`ifdef DEBOUNCE_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct {
    int         ed;
    logic [1:0] db;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [1:0] button_in;
  logic [1:0] db_a, pr_a, rl_a, lg_a;
  logic [1:0] db_b, pr_b, rl_b, lg_b;

  int   checks = 0;
  int   fails  = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  int   ecnt = 0;
  logic hist [2][2][0:8191];
  logic mdb [2][2];
  int   last_acc [2][2];
  int   press_ed [2][2];
  int   n_press_b0 = 0;
  int   n_long_b0  = 0;
  int   hold [2];

  debounce_multi #(
    .N_CH(2), .CNT_W(8), .DB_CYCLES(DB), .ACTIVE_LOW(0)
`ifdef DEBOUNCE_LONGPRESS_EN
    , .LONG_CYCLES(LONG)
`endif
  ) dut_a (
    .clk(clk), .reset(reset), .button_in(button_in),
    .db_out(db_a), .press_pulse(pr_a), .release_pulse(rl_a), .long_pulse(lg_a)
  );

  debounce_multi #(
    .N_CH(2), .CNT_W(8), .DB_CYCLES(DB), .ACTIVE_LOW(1)
`ifdef DEBOUNCE_LONGPRESS_EN
    , .LONG_CYCLES(LONG)
`endif
  ) dut_b (
    .clk(clk), .reset(reset), .button_in(button_in),
    .db_out(db_b), .press_pulse(pr_b), .release_pulse(rl_b), .long_pulse(lg_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_db_a"}, db_a, 2'b00);
    chk({tag, "_press_a"}, pr_a, 2'b00);
    chk({tag, "_release_a"}, rl_a, 2'b00);
    chk({tag, "_long_a"}, lg_a, 2'b00);
    chk({tag, "_db_b"}, db_b, 2'b00);
    chk({tag, "_press_b"}, pr_b, 2'b00);
    chk({tag, "_release_b"}, rl_b, 2'b00);
    chk({tag, "_long_b"}, lg_b, 2'b00);
  endtask

  function automatic logic [1:0] mdbv(input int d);
    return {mdb[d][1], mdb[d][0]};
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  // Reference: a level is accepted once the last DB samples it saw (two edges
  // of synchroniser delay behind) all differ from the current debounced level,
  // counting only samples taken after the previous acceptance.
  task automatic model_step();
    ev_t        e;
    logic       s;
    int         lo;
    bit         ok;
    logic [1:0] pr, rl, lg;
    if (reset) begin
      ecnt = 0;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          mdb[d][c]      = 1'b0;
          last_acc[d][c] = 0;
          press_ed[d][c] = -1000000;
        end
        while (qsize(d) > 0) begin
          e = qfront(d);
          qpop(d);
          checks++;
          fails++;
          $display("FAIL missed_pulse dut%0d: nothing seen, required press=%b release=%b long=%b at edge %0d",
                   d, e.pr, e.rl, e.lg, e.ed);
        end
      end
    end else begin
      ecnt++;
      for (int d = 0; d < 2; d++) begin
        pr = 2'b00; rl = 2'b00; lg = 2'b00;
        for (int c = 0; c < 2; c++) begin
          s = button_in[c] ^ (d == 1);
          hist[d][c][ecnt] = s;
          if (LONG_EN && mdb[d][c] && (ecnt - press_ed[d][c] == LONG)) lg[c] = 1'b1;
          lo = ecnt - DB - 1;
          ok = (lo >= 1) && (lo >= last_acc[d][c] - 1);
          if (ok) begin
            for (int k = lo; k <= ecnt - 2; k++) begin
              if (hist[d][c][k] == mdb[d][c]) ok = 1'b0;
            end
          end
          if (ok) begin
            mdb[d][c]      = ~mdb[d][c];
            last_acc[d][c] = ecnt;
            if (mdb[d][c]) begin
              pr[c]          = 1'b1;
              press_ed[d][c] = ecnt;
            end else begin
              rl[c] = 1'b1;
            end
          end
        end
        if ((pr | rl | lg) != 2'b00) begin
          e.ed = ecnt; e.db = mdbv(d); e.pr = pr; e.rl = rl; e.lg = lg;
          if (d == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
  endtask

  task automatic mon(input int d, input logic [1:0] db, input logic [1:0] pr,
                     input logic [1:0] rl, input logic [1:0] lg);
    ev_t e;
    while (qsize(d) > 0 && qfront(d).ed < ecnt) begin
      e = qfront(d);
      qpop(d);
      checks++;
      fails++;
      $display("FAIL missed_pulse dut%0d: nothing seen, required press=%b release=%b long=%b at edge %0d",
               d, e.pr, e.rl, e.lg, e.ed);
    end
    if ((pr | rl | lg) != 2'b00) begin
      if (qsize(d) == 0 || qfront(d).ed != ecnt) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse dut%0d: got press=%b release=%b long=%b at edge %0d, required none",
                 d, pr, rl, lg, ecnt);
      end else begin
        e = qfront(d);
        qpop(d);
        chk($sformatf("press_dut%0d", d), pr, e.pr);
        chk($sformatf("release_dut%0d", d), rl, e.rl);
        chk($sformatf("long_dut%0d", d), lg, e.lg);
        chk($sformatf("db_at_pulse_dut%0d", d), db, e.db);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon(0, db_a, pr_a, rl_a, lg_a);
      mon(1, db_b, pr_b, rl_b, lg_b);
      if (pr_b[0]) n_press_b0++;
      if (lg_b[0]) n_long_b0++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", ecnt);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    button_in = 2'b11;
    cyc(2);
    chk_zero("rst_early");
    cyc(3);
    chk_zero("rst_late");
    reset = 1'b0;
    cyc(30);
    chk("pwr_on_db_a", db_a, 2'b11);
    chk("pwr_on_db_b", db_b, mdbv(1));

    button_in = 2'b00;
    cyc(40);
    chk("idle_db_a", db_a, 2'b00);
    // Bounce highs stay one cycle short of the acceptance window.
    repeat (3) begin
      button_in[0] = 1'b1;
      cyc(15);
      button_in[0] = 1'b0;
      cyc(40);
    end
    chk("bounce_db_a", db_a, 2'b00);
    button_in[0] = 1'b1;
    cyc(2000);
    chk("held_db_a", db_a, 2'b01);
    chk("held_db_b", db_b, mdbv(1));

    button_in[0] = 1'b0;
    cyc(10);
    button_in[0] = 1'b1;
    cyc(30);
    chk("glitch_db_a", db_a, 2'b01);
    button_in[0] = 1'b0;
    cyc(20);
    chk("long_low_db_a", db_a, 2'b00);
    cyc(10);

    button_in[1] = 1'b1;
    cyc(30);
    chk("ch1_up_db_a", db_a, 2'b10);
    button_in = 2'b01;
    cyc(30);
    chk("cross_db_a", db_a, 2'b01);
    chk("cross_db_b", db_b, mdbv(1));

    button_in[0] = 1'b0;
    cyc(30);
    chk("pre_mid_db_a", db_a, 2'b00);
    button_in[0] = 1'b1;
    cyc(12);
    reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    cyc(2);
    chk_zero("rst_mid_hold");
    reset = 1'b0;
    cyc(10);
    chk("restart_db_a", db_a, 2'b00);
    cyc(10);
    chk("restart_done_db_a", db_a, 2'b01);

    hold[0] = 5;
    hold[1] = 9;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          button_in[c] = ~button_in[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 18))
                                                 : int'($urandom_range(1, 90));
        end else begin
          hold[c]--;
        end
      end
      cyc(1);
    end
    cyc(40);
    chk("rand_db_a", db_a, mdbv(0));
    chk("rand_db_b", db_b, mdbv(1));

    button_in = 2'b11;
    cyc(40);
    chk("al_idle_db_b", db_b, 2'b00);
    n_press_b0 = 0;
    n_long_b0  = 0;
    button_in[0] = 1'b0;
    cyc(200);
    chk("al_db_b", db_b, 2'b01);
    chk_int("al_press_count_b0", n_press_b0, 1);
    chk_int("al_long_count_b0", n_long_b0, LONG_EN ? 1 : 0);

    cyc(30);
    chk_int("leftover_dut0", q0.size(), 0);
    chk_int("leftover_dut1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", fails, checks);
    $finish;
  end

endmodule
